// File: rtl/s526_state_bank.sv
// s526 present-state register bank with scan shift, hold, and an optional trace FIFO of state changes.
// Optional feature: define S526_STATE_BANK_TRACE_EN to build the 4-entry trace FIFO; otherwise trace outputs are 0.
module s526_state_bank (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] ns_i,
  input  logic        hold_i,
  input  logic        scan_en_i,
  input  logic        scan_in_i,
  output logic        scan_out_o,
  output logic [20:0] state_o,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [20:0] trace_data_o,
  output logic        trace_ovf_o,
  input  logic        trace_clr_i
);

  logic [20:0] state_q;

  // Scan shift beats hold, hold beats a functional load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else if (scan_en_i) begin
      state_q <= {state_q[19:0], scan_in_i};
    end else if (!hold_i) begin
      state_q <= ns_i;
    end
  end

  assign state_o    = state_q;
  assign scan_out_o = state_q[20];

`ifdef S526_STATE_BANK_TRACE_EN
  // Trace handshake: an entry transfers on any edge where trace_valid_o and
  // trace_ready_i are both high; trace_data_o is stable while valid and unpopped.
  logic [20:0] mem_q [4];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q;
  logic        ovf_q;
  logic        push_req;
  logic        do_pop;
  logic        do_push;
  logic        full;

  assign push_req = !scan_en_i && !hold_i && (ns_i != state_q);
  assign full     = (count_q == 3'd4);
  assign do_pop   = (count_q != 3'd0) && trace_ready_i;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push  = push_req && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (trace_clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, do_push} - {2'b00, do_pop};
      if (push_req && full && !do_pop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: empty entries are masked on the output.
  always_ff @(posedge clk) begin
    if (do_push && !trace_clr_i) mem_q[wr_ptr_q] <= ns_i;
  end

  assign trace_valid_o = (count_q != 3'd0);
  assign trace_data_o  = trace_valid_o ? mem_q[rd_ptr_q] : 21'h0;
  assign trace_ovf_o   = ovf_q;
`else
  logic unused_trace_inputs;
  assign unused_trace_inputs = trace_ready_i ^ trace_clr_i;

  assign trace_valid_o = 1'b0;
  assign trace_data_o  = 21'h0;
  assign trace_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_s526_state_bank.sv
// Bench for s526_state_bank: directed scenarios then random traffic, checked against a queue-based model.
// Trace expectations follow S526_STATE_BANK_TRACE_EN so the same bench serves both builds.
module tb_s526_state_bank;

`ifdef S526_STATE_BANK_TRACE_EN
  localparam bit TRACE_EN = 1'b1;
`else
  localparam bit TRACE_EN = 1'b0;
`endif
  localparam logic [20:0] MASK = 21'h1FFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] ns_i = '0;
  logic        hold_i = 1'b0;
  logic        scan_en_i = 1'b0;
  logic        scan_in_i = 1'b0;
  logic        scan_out_o;
  logic [20:0] state_o;
  logic        trace_valid_o;
  logic        trace_ready_i = 1'b0;
  logic [20:0] trace_data_o;
  logic        trace_ovf_o;
  logic        trace_clr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [20:0] m_state = '0;
  logic [20:0] exp_q[$];
  logic        m_ovf = 1'b0;

  s526_state_bank dut (
    .clk(clk), .rst(rst), .ns_i(ns_i), .hold_i(hold_i), .scan_en_i(scan_en_i),
    .scan_in_i(scan_in_i), .scan_out_o(scan_out_o), .state_o(state_o),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_data_o(trace_data_o), .trace_ovf_o(trace_ovf_o), .trace_clr_i(trace_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [20:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 21'h0;
    check({tag, ".state"}, state_o, m_state);
    check({tag, ".scan_out"}, {20'h0, scan_out_o}, {20'h0, m_state[20]});
    check({tag, ".valid"}, {20'h0, trace_valid_o}, {20'h0, exp_q.size() > 0});
    check({tag, ".data"}, trace_data_o, head);
    check({tag, ".ovf"}, {20'h0, trace_ovf_o}, {20'h0, m_ovf});
  endtask

  task automatic model_reset();
    m_state = '0;
    exp_q.delete();
    m_ovf = 1'b0;
  endtask

  // Model one edge from the rules: priority scan > hold > load; FIFO as a bounded queue.
  task automatic model_edge();
    bit push;
    push = !scan_en_i && !hold_i && (ns_i != m_state);
    if (TRACE_EN) begin
      if (trace_clr_i) begin
        exp_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (trace_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (push) begin
          if (exp_q.size() < 4) exp_q.push_back(ns_i);
          else m_ovf = 1'b1;
        end
      end
    end
    if (scan_en_i) m_state = ((m_state << 1) | {20'h0, scan_in_i}) & MASK;
    else if (!hold_i) m_state = ns_i;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic drive(input logic [20:0] ns, input bit hold, input bit scan, input bit sin,
                       input bit ready, input bit clr, input string tag);
    ns_i = ns; hold_i = hold; scan_en_i = scan; scan_in_i = sin;
    trace_ready_i = ready; trace_clr_i = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check({tag, ".state"}, state_o, 21'h0);
    check({tag, ".valid"}, {20'h0, trace_valid_o}, 21'h0);
    check({tag, ".ovf"}, {20'h0, trace_ovf_o}, 21'h0);
    check({tag, ".data"}, trace_data_o, 21'h0);
    check({tag, ".scan_out"}, {20'h0, scan_out_o}, 21'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [20:0] pattern;
    logic [20:0] prior;
    logic [20:0] seen;
    logic [20:0] loads[6];

    // reset held from time 0
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // same next-state twice: one push only
    drive(21'h1, 0, 0, 0, 0, 0, "ns1_a");
    check("ns1_state", state_o, 21'h1);
    drive(21'h1, 0, 0, 0, 0, 0, "ns1_b");
    check("ns1_data", trace_data_o, TRACE_EN ? 21'h1 : 21'h0);
    drive(21'h0, 1, 0, 0, 1, 0, "ns1_pop");
    check("ns1_one_entry", {20'h0, trace_valid_o}, 21'h0);

    // hold blocks load and push
    drive(21'h155, 1, 0, 0, 0, 0, "hold");
    check("hold_state", state_o, 21'h1);

    // scan in pattern, capture prior state from scan_out
    pattern = 21'h0A5A5;
    prior = state_o;
    seen = '0;
    for (int i = 0; i < 21; i++) begin
      seen = {seen[19:0], scan_out_o};
      drive(21'h1FFFFF, 0, 1, pattern[20-i], 0, 0, "scan");
    end
    check("scan_state", state_o, 21'h0A5A5);
    check("scan_prior", seen, prior);

    // overflow: five distinct loads, nothing consumed
    drive(21'h0, 1, 0, 0, 0, 1, "clr0");
    for (int i = 0; i < 6; i++) loads[i] = 21'h10000 + 21'(i * 21'h111);
    for (int i = 0; i < 5; i++) drive(loads[i], 0, 0, 0, 0, 0, "ovf_load");
    check("ovf_flag", {20'h0, trace_ovf_o}, {20'h0, TRACE_EN});
    check("ovf_head", trace_data_o, TRACE_EN ? loads[0] : 21'h0);
    drive(loads[5], 0, 0, 0, 1, 0, "full_pushpop");
    check("full_head_adv", trace_data_o, TRACE_EN ? loads[1] : 21'h0);
    check("full_ovf_sticky", {20'h0, trace_ovf_o}, {20'h0, TRACE_EN});

    // clear while full with push and pop pending
    drive(21'h0BEEF, 0, 0, 0, 1, 1, "clr_full");
    check("clr_valid", {20'h0, trace_valid_o}, 21'h0);
    check("clr_ovf", {20'h0, trace_ovf_o}, 21'h0);
    check("clr_state", state_o, 21'h0BEEF);

    // reset mid-scan and mid-FIFO activity
    drive(21'h00123, 0, 0, 0, 0, 0, "pre_rst_a");
    drive(21'h00456, 0, 0, 0, 0, 0, "pre_rst_b");
    drive(21'h0, 0, 1, 1, 0, 0, "pre_rst_scan");
    reset_pulse("rst_mid");
    drive(21'h0, 0, 1, 1, 0, 0, "post_rst_scan");
    drive(21'h00777, 0, 0, 0, 0, 0, "post_rst_load");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [20:0] ns;
      bit hold, scan, ready, clr;
      ns    = ($urandom_range(0, 3) == 0) ? m_state : (21'($urandom()) & MASK);
      scan  = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 24) == 0);
      drive(ns, hold, scan, 1'($urandom_range(0, 1)), ready, clr, "rand");
      if ($urandom_range(0, 99) == 0) reset_pulse("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/s526_state_bank.md
S526_STATE_BANK -- requirements
Module: s526_state_bank

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all flops.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-003 The block SHALL have port ns_i, input, 21 bits: next-state vector from the s526 combinational stage.
REQ-004 The block SHALL have port hold_i, input, 1 bit: freezes the state register when high.
REQ-005 The block SHALL have port scan_en_i, input, 1 bit: selects scan shift mode.
REQ-006 The block SHALL have port scan_in_i, input, 1 bit: scan chain serial input.
REQ-007 The block SHALL have port scan_out_o, output, 1 bit: scan chain serial output, equal to state_o[20].
REQ-008 The block SHALL have port state_o, output, 21 bits: registered present state, fed back to the combinational stage.
REQ-009 The block SHALL have port trace_valid_o, output, 1 bit: trace FIFO not empty.
REQ-010 The block SHALL have port trace_ready_i, input, 1 bit: trace consumer accepts the head entry.
REQ-011 The block SHALL have port trace_data_o, output, 21 bits: head entry of the trace FIFO.
REQ-012 The block SHALL have port trace_ovf_o, output, 1 bit: sticky trace overflow flag.
REQ-013 The block SHALL have port trace_clr_i, input, 1 bit: synchronous flush of the trace FIFO and overflow flag.

Function
REQ-014 State update priority per clk edge SHALL be: scan_en_i=1 -> state <= {state[19:0], scan_in_i}; else hold_i=1 -> state unchanged; else state <= ns_i.
REQ-015 state_o SHALL be a direct flop output with no combinational path from any input; ns_i to state_o latency is 1 cycle.
REQ-016 A functional load is an edge with scan_en_i=0, hold_i=0 and ns_i != state_o; only a functional load SHALL push an entry, and the pushed value is ns_i, i.e. the new state.
REQ-017 Scan shifts and held cycles SHALL never push.
REQ-018 The trace FIFO SHALL be 4 entries deep with 2-bit pointers that wrap modulo 4 and a 3-bit occupancy count of 0..4.
REQ-019 A pop SHALL occur when trace_valid_o=1 and trace_ready_i=1; trace_data_o shows the head entry while valid and reads 0 when empty.
REQ-020 Push while empty SHALL give no bypass: trace_valid_o rises on the edge that writes the entry.
REQ-021 Push with simultaneous pop while full SHALL accept both; count stays 4.
REQ-022 Push without pop while full SHALL drop the entry and set trace_ovf_o=1 on that edge.
REQ-023 Push with pop while count is between 1 and 3 SHALL leave the count unchanged.
REQ-024 trace_clr_i=1 SHALL empty the FIFO, reset both pointers, clear trace_ovf_o and ignore any push or pop in that cycle; it SHALL NOT affect state_o.
REQ-025 trace_ovf_o SHALL stay at 1 until trace_clr_i or rst.

Reset
REQ-026 While rst=1, the block SHALL asynchronously force state_o=0, scan_out_o=0, FIFO empty, pointers=0, trace_valid_o=0, trace_data_o=0 and trace_ovf_o=0.
REQ-027 Reset asserted in the middle of a scan shift or FIFO activity SHALL discard all contents; the first edge after deassertion follows REQ-014 normally.

Configuration
REQ-028 The macro S526_STATE_BANK_TRACE_EN, when defined, SHALL compile in the trace FIFO as specified.
REQ-029 When S526_STATE_BANK_TRACE_EN is undefined, the block SHALL contain no FIFO storage, SHALL tie trace_valid_o, trace_data_o and trace_ovf_o to 0, and SHALL ignore trace_ready_i and trace_clr_i; state and scan behaviour are unchanged.

Verification
REQ-030 The bench SHALL cover: rst pulse mid-run -> state_o=0, trace_valid_o=0 and trace_ovf_o=0 immediately, before any clk edge.
REQ-031 The bench SHALL cover: ns_i=21'h1 then 21'h1 again, hold_i=0 -> state_o=21'h1 after 1 edge; exactly one entry pushed; trace_data_o=21'h1.
REQ-032 The bench SHALL cover: hold_i=1 with ns_i=21'h155 -> state_o unchanged and no push.
REQ-033 The bench SHALL cover: scan_en_i=1 with 21 shifts of pattern 21'h0A5A5 on scan_in_i -> state_o=21'h0A5A5; scan_out_o emits the prior state MSB first; no pushes.
REQ-034 The bench SHALL cover: 5 distinct loads with trace_ready_i=0 -> count 4, trace_ovf_o=1, entries are loads 1-4; then a 6th load with trace_ready_i=1 -> count stays 4 and the head advances.
REQ-035 The bench SHALL cover: trace_clr_i=1 while full with a push and pop pending -> FIFO empty, trace_ovf_o=0 and state_o loads ns_i; a build without the macro shows trace outputs constantly 0.
